// File: rtl/keypad_pkg.sv
// Shared keypad definitions: driver FSM states, special key codes and the
// code -> one-hot key mapping also used by the scanner tables.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } kp_state_e;

    localparam logic [3:0]  KEY_STAR     = 4'd10;
    localparam int unsigned KEY_ZERO_BIT = 10;
    localparam logic [3:0]  KEY_HASH     = 4'd11;

    // Codes 0..11 are keys; 12..15 are rejected.
    function automatic logic code_is_valid(input logic [3:0] code);
        return (code <= KEY_HASH);
    endfunction

    // 1..9 -> bit code-1, '*' -> bit 9, 0 -> bit 10, '#' -> bit 11, invalid -> 0.
    function automatic logic [11:0] code_to_onehot(input logic [3:0] code);
        logic [11:0] oh;
        oh = '0;
        case (code)
            4'd0:     oh[KEY_ZERO_BIT] = 1'b1;
            KEY_STAR: oh[9]            = 1'b1;
            KEY_HASH: oh[11]           = 1'b1;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                      oh[code - 4'd1]  = 1'b1;
            default:  oh               = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// Key-code queue: synchronous FIFO, 4 bits wide, DEPTH entries (power of 2).
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module keypad_code_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [3:0] din,
    input  logic       pop,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [3:0]  mem_q [DEPTH];
    logic [3:0]  mem_d [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    // Next pointer and storage values for accepted push/pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d                = wr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/keypad_press_gen.sv
// Keypad press generator: pops queued key codes and emits timed one-hot
// press/release patterns on keypad_out.
// Optional feature macro: KEYPAD_DRV_BOUNCE_EN (leading chatter in each press).
module keypad_press_gen
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned BOUNCE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_code,
    output logic [11:0] keypad_out,
    output logic        busy,
    output logic        err_invalid
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
`ifdef KEYPAD_DRV_BOUNCE_EN
    localparam bit BOUNCE_EN = 1'b1;
`else
    localparam bit BOUNCE_EN = 1'b0;
`endif

    kp_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         code_q, code_d;
    logic [11:0]        keypad_out_q, keypad_out_d;
    logic               err_q, err_d;

    logic               fifo_pop;
    logic [3:0]         fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   press_idx;
    logic               bounce_gap;

    keypad_code_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (in_valid),
        .din   (in_code),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign busy        = !fifo_empty || (state_q != ST_IDLE);
    assign keypad_out  = keypad_out_q;
    assign err_invalid = err_q;

    // Position within the press (0 = first cycle); odd positions inside the
    // bounce window are released when chatter is enabled.
    assign press_idx  = CNT_W'(HOLD_CYCLES - 1) - cnt_q;
    assign bounce_gap = BOUNCE_EN && (press_idx < CNT_W'(BOUNCE_CYCLES)) && press_idx[0];

    // Next state, hold/gap counter, queue pop and output pattern.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        err_d        = 1'b0;
        fifo_pop     = 1'b0;
        // Output lags the state by one cycle so the press starts two edges after acceptance.
        keypad_out_d = (state_q == ST_PRESS && !bounce_gap) ? code_to_onehot(code_q) : '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (code_is_valid(fifo_dout)) begin
                        state_d = ST_PRESS;
                        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                        code_d  = fifo_dout;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, code and output registers; reset releases the keypad at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            keypad_out_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            keypad_out_q <= keypad_out_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_keypad_press_gen.sv
// Directed bench for keypad_press_gen with a scanner-side decode of keypad_out.
module tb_keypad_press_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_code = 4'd0;
    logic        in_ready;
    logic [11:0] keypad_out;
    logic        busy;
    logic        err_invalid;

    int n_checks = 0;
    int n_fail   = 0;

    // Press monitor state
    bit          mon_en = 1'b0;
    logic [11:0] pats[$];
    int          lens[$];
    int          gaps[$];
    int          err_pulses;
    bit          in_press;
    bit          had_press;
    logic [11:0] cur_pat;
    int          cur_len;
    int          zero_len;

    logic [3:0]  stim_q[$];

    always #5 clk = ~clk;

    keypad_press_gen #(
        .HOLD_CYCLES   (8),
        .GAP_CYCLES    (4),
        .FIFO_DEPTH    (4),
        .BOUNCE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .keypad_out  (keypad_out),
        .busy        (busy),
        .err_invalid (err_invalid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scanner-side inverse mapping; 15 marks a non-key pattern.
    function automatic logic [3:0] decode(input logic [11:0] p);
        case (p)
            12'h001: return 4'd1;
            12'h002: return 4'd2;
            12'h004: return 4'd3;
            12'h008: return 4'd4;
            12'h010: return 4'd5;
            12'h020: return 4'd6;
            12'h040: return 4'd7;
            12'h080: return 4'd8;
            12'h100: return 4'd9;
            12'h200: return 4'd10;
            12'h400: return 4'd0;
            12'h800: return 4'd11;
            default: return 4'd15;
        endcase
    endfunction

    // Records each press pattern, its length and the zero run before it.
    always @(negedge clk) begin
        if (!mon_en) begin
            pats.delete();
            lens.delete();
            gaps.delete();
            err_pulses = 0;
            in_press   = 1'b0;
            had_press  = 1'b0;
            cur_len    = 0;
            zero_len   = 0;
        end else begin
            if (keypad_out != 12'h000) begin
                if (!in_press) begin
                    in_press = 1'b1;
                    cur_pat  = keypad_out;
                    cur_len  = 1;
                    if (had_press) gaps.push_back(zero_len);
                end else begin
                    cur_len++;
                end
            end else begin
                if (in_press) begin
                    pats.push_back(cur_pat);
                    lens.push_back(cur_len);
                    in_press  = 1'b0;
                    had_press = 1'b1;
                    zero_len  = 0;
                end
                zero_len++;
            end
            if (err_invalid) err_pulses++;
        end
    end

    task automatic mon_restart();
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Offer each code in stim_q, waiting on in_ready; optionally check back-pressure.
    task automatic stream(input int full_at);
        for (int i = 0; i < stim_q.size(); i++) begin
            in_valid = 1'b1;
            in_code  = stim_q[i];
            for (int w = 0; w < 60 && !in_ready; w++) @(negedge clk);
            if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            if (i == full_at) check("t3_in_ready_full", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_code  = 4'hF;
    endtask

    task automatic wait_presses(input string tag, input int n);
        for (int c = 0; c < 400 && pats.size() < n; c++) @(negedge clk);
        check(tag, 32'(pats.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        check(tag, 32'(busy), 32'd0);
    endtask

    // Single code from idle: k = negedges after the accepting edge.
    task automatic run_single(input string tag, input logic [3:0] code,
                              input logic [11:0] pat, input bit bounce);
        logic [11:0] e;
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_code  = 4'hE;
        for (int k = 0; k < 14; k++) begin
            if (k <= 10) begin
                e = (k >= 2 && k <= 9) ? pat : 12'h000;
                if (bounce && k >= 2 && (k - 2) < 3 && ((k - 2) % 2) == 1) e = 12'h000;
                check($sformatf("%s_out_k%0d", tag, k), 32'(keypad_out), 32'(e));
            end
            if (k == 12) check($sformatf("%s_busy_gap", tag), 32'(busy), 32'd1);
            if (k == 13) check($sformatf("%s_busy_idle", tag), 32'(busy), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [11:0] exp_pat[4];
        logic [3:0]  exp_code[4];
        int          nz;
        int          busy_cnt;

        exp_pat  = '{12'h040, 12'h100, 12'h400, 12'h800};
        exp_code = '{4'd7, 4'd9, 4'd0, 4'd11};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_keypad_out", 32'(keypad_out), 32'h0);
        check("rst_err", 32'(err_invalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single key '1'
        run_single("t1", 4'd1, 12'h001, 1'b0);

        // 2: back-to-back 7, 9, 0, 11
        mon_restart();
        stim_q = '{4'd7, 4'd9, 4'd0, 4'd11};
        stream(-1);
        wait_presses("t2_press_count", 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_pat%0d", i), 32'(pats[i]), 32'(exp_pat[i]));
            check($sformatf("t2_len%0d", i), 32'(lens[i]), 32'd8);
            check($sformatf("t2_scan%0d", i), 32'(decode(pats[i])), 32'(exp_code[i]));
        end
        for (int i = 0; i < 3; i++) check($sformatf("t2_gap%0d", i), 32'(gaps[i]), 32'd5);
        wait_idle("t2_idle");

        // 3: back-pressure with FSM stalled in PRESS
        mon_restart();
        stim_q = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        stream(4);
        wait_presses("t3_press_count", 7);
        wait_idle("t3_idle");
        repeat (4) @(negedge clk);
        check("t3_no_dup", 32'(pats.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t3_scan%0d", i), 32'(decode(pats[i])), 32'(i + 2));
            check($sformatf("t3_len%0d", i), 32'(lens[i]), 32'd8);
        end

        // 4: invalid code 13 then 3
        mon_restart();
        in_valid = 1'b1;
        in_code  = 4'd13;
        @(posedge clk);
        @(negedge clk);
        check("t4_err_k0", 32'(err_invalid), 32'd0);
        in_code = 4'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_err_k1", 32'(err_invalid), 32'd1);
        @(negedge clk);
        check("t4_err_k2", 32'(err_invalid), 32'd0);
        wait_presses("t4_press_count", 1);
        wait_idle("t4_idle");
        repeat (4) @(negedge clk);
        check("t4_only_one_press", 32'(pats.size()), 32'd1);
        check("t4_pat", 32'(pats[0]), 32'h004);
        check("t4_len", 32'(lens[0]), 32'd8);
        check("t4_err_pulses", 32'(err_pulses), 32'd1);
        mon_en = 1'b0;

        // 5: reset during the third PRESS cycle with a code still queued
        in_valid = 1'b1;
        in_code  = 4'd4;
        @(posedge clk);
        @(negedge clk);
        in_code = 4'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pre_out", 32'(keypad_out), 32'h008);
        check("t5_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_out", 32'(keypad_out), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd1);
        check("t5_rst_err", 32'(err_invalid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nz = 0;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (keypad_out != 12'h000) nz++;
            if (busy) busy_cnt++;
        end
        check("t5_no_resume", 32'(nz), 32'd0);
        check("t5_flushed", 32'(busy_cnt), 32'd0);

        // 6: key '5', with chatter when the feature is built in
`ifdef KEYPAD_DRV_BOUNCE_EN
        run_single("t6", 4'd5, 12'h010, 1'b1);
`else
        run_single("t6", 4'd5, 12'h010, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
